// File: rtl/vpi_check_sched_if.sv
// Request/check/ack and statistics bundle between the VPI host and vpi_check_sched.
// The host side takes the master modport and the scheduler takes the slave modport.
interface vpi_check_sched_if #(
    parameter int NUM_SLOTS = 6,
    parameter int CNT_W     = 16
);
    localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0] req;
    logic [NUM_SLOTS-1:0] mismatch_in;
    logic                 clr_counts;
    logic [NUM_SLOTS-1:0] check;
    logic [NUM_SLOTS-1:0] ack;
    logic                 busy;
    logic [CNT_W-1:0]     pass_count;
    logic [CNT_W-1:0]     fail_count;
    logic                 fail;
    logic [SEL_W-1:0]     last_fail_slot;

    modport master (
        output req, mismatch_in, clr_counts,
        input  check, ack, busy, pass_count, fail_count, fail, last_fail_slot
    );

    modport slave (
        input  req, mismatch_in, clr_counts,
        output check, ack, busy, pass_count, fail_count, fail, last_fail_slot
    );
endinterface

// File: rtl/vpi_check_sched.sv
// Round-robin check-pulse sequencer with saturating pass/fail statistics.
// Optional feature macro: VPI_CHECK_SCHED_HALT_ON_FAIL_EN (stop in HALT after a mismatch).
module vpi_check_sched #(
    parameter int NUM_SLOTS = 6,
    parameter int SETTLE    = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    vpi_check_sched_if.slave bus
);
    localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PULSE,
        ST_SETTLE,
`ifdef VPI_CHECK_SCHED_HALT_ON_FAIL_EN
        ST_SAMPLE,
        ST_HALT
`else
        ST_SAMPLE
`endif
    } state_t;

    state_t               r_state;
    logic [SEL_W-1:0]     r_sel;
    logic [SEL_W-1:0]     r_last_grant;
    logic [7:0]           r_cnt;
    logic [NUM_SLOTS-1:0] r_check;
    logic [NUM_SLOTS-1:0] r_ack;
    logic                 r_busy;
    logic [CNT_W-1:0]     r_pass;
    logic [CNT_W-1:0]     r_fail;
    logic                 r_sticky;
    logic [SEL_W-1:0]     r_lfs;

    logic                 w_any;
    logic [SEL_W-1:0]     w_grant;
    logic                 w_mism;

    // Round-robin search: first requesting slot after the previous grant, wrapping once.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_any   = 1'b0;
        w_grant = r_last_grant;
        for (int k = 1; k <= NUM_SLOTS; k++) begin
            int idx;
            idx = int'(r_last_grant) + k;
            if (idx >= NUM_SLOTS) idx = idx - NUM_SLOTS;
            if (!w_any && bus.req[SEL_W'(idx)]) begin
                w_any   = 1'b1;
                w_grant = SEL_W'(idx);
            end
        end
    end

    assign w_mism = bus.mismatch_in[r_sel];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_sel        <= '0;
            r_last_grant <= SEL_W'(NUM_SLOTS - 1);
            r_cnt        <= '0;
            r_check      <= '0;
            r_ack        <= '0;
            r_busy       <= 1'b0;
            r_pass       <= '0;
            r_fail       <= '0;
            r_sticky     <= 1'b0;
            r_lfs        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_sel        <= w_grant;
                        r_last_grant <= w_grant;
                        r_check      <= NUM_SLOTS'(1) << w_grant;
                        r_busy       <= 1'b1;
                        r_state      <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    r_check <= '0;
                    r_cnt   <= 8'(SETTLE - 1);
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_cnt == 8'd0) begin
                        r_ack   <= NUM_SLOTS'(1) << r_sel;
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                ST_SAMPLE: begin
                    r_ack <= '0;
`ifdef VPI_CHECK_SCHED_HALT_ON_FAIL_EN
                    if (w_mism) begin
                        r_state <= ST_HALT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    if (bus.clr_counts) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
`else
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
`endif
                default: begin
                    r_check <= '0;
                    r_ack   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase

            // A clear in the same cycle as SAMPLE discards that result.
            if (bus.clr_counts) begin
                r_pass   <= '0;
                r_fail   <= '0;
                r_sticky <= 1'b0;
                r_lfs    <= '0;
            end else if (r_state == ST_SAMPLE) begin
                if (w_mism) begin
                    if (r_fail != '1) r_fail <= r_fail + 1'b1;
                    r_sticky <= 1'b1;
                    r_lfs    <= r_sel;
                end else if (r_pass != '1) begin
                    r_pass <= r_pass + 1'b1;
                end
            end
        end
    end

    assign bus.check          = r_check;
    assign bus.ack            = r_ack;
    assign bus.busy           = r_busy;
    assign bus.pass_count     = r_pass;
    assign bus.fail_count     = r_fail;
    assign bus.fail           = r_sticky;
    assign bus.last_fail_slot = r_lfs;
endmodule

// File: doc/vpi_check_sched.md
# vpi_check_sched

Round-robin scheduler that sequences the compare-check pulses of the public `arr` test slots, each holding a `sig`/`rfr` pair. Requesters, typically the VPI host through public_flat_rw signals, raise a per-slot request after writing that slot's `sig`/`rfr`. The scheduler grants one slot at a time, pulses that slot's `check`, waits a settle window and samples the slot's mismatch flag. It then acknowledges the requester and accumulates pass/fail statistics that the host can read back through VPI.

## Interface
- `NUM_SLOTS`, default 6: number of check slots; legal range 2..32.
- `SETTLE`, default 2: idle cycles between the `check` pulse and sampling; legal range 1..255.
- `CNT_W`, default 16: width of the pass/fail counters.
- `clk`  in  1  sole clock; all state changes on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  NUM_SLOTS  level request per slot; held until `ack` for that slot.
- `mismatch_in`  in  NUM_SLOTS  per-slot compare result (`sig != rfr`); only sampled for the granted slot.
- `clr_counts`  in  1  synchronous clear of statistics and sticky fail.
- `check`  out  NUM_SLOTS  one-hot check pulse to the granted slot.
- `ack`  out  NUM_SLOTS  one-hot, one-cycle completion strobe.
- `busy`  out  1  high in every state except IDLE.
- `pass_count`  out  CNT_W  saturating count of passing checks.
- `fail_count`  out  CNT_W  saturating count of failing checks.
- `fail`  out  1  sticky; set on the first mismatch.
- `last_fail_slot`  out  max(1,$clog2(NUM_SLOTS))  index of the most recent failing slot.

## Operation
- States:
  - IDLE: exits when any `req` is high; the next state is PULSE and the grant is registered into `sel`.
  - PULSE: exactly 1 cycle. Next state is SETTLE.
  - SETTLE: exactly `SETTLE` cycles, with a down-counter. Next state is SAMPLE.
  - SAMPLE: exactly 1 cycle. Next state is IDLE, or HALT (see Configuration).
- Arbitration is round-robin. The search starts at `(last_grant+1) mod NUM_SLOTS`. `last_grant` resets to NUM_SLOTS-1, so slot 0 has first priority after reset.
- `check[sel]` is registered and high only during PULSE. `ack[sel]` is registered and high only during SAMPLE. All other bits are 0.
- In SAMPLE, `mismatch_in[sel]` is evaluated:
  - 0: `pass_count` increments.
  - 1: `fail_count` increments, `fail` is set, and `last_fail_slot` is set to `sel`.
  - Both counters saturate at all-ones.
- A `req` that drops after grant does not cancel the check; the sequence completes and `ack` still fires.
- A new `req` arriving mid-sequence waits for IDLE.
- `clr_counts` zeroes `pass_count`, `fail_count`, `fail` and `last_fail_slot`. When it coincides with a SAMPLE update, clear wins and that result is discarded.
- `clr_counts` does not affect the FSM or the arbitration pointer, except for leaving HALT.
- Reset (`rst_n` low), including mid-operation:
  - All outputs go to 0 immediately.
  - State returns to IDLE.
  - `last_grant` returns to NUM_SLOTS-1.
  - No `ack` is issued for the aborted check.

## Timing
- `req` high at posedge E0 while in IDLE, then:
  - `check` is high during E0→E1.
  - SETTLE occupies E1→E(1+SETTLE).
  - `ack` is high during E(1+SETTLE)→E(2+SETTLE), and the counters update at E(2+SETTLE).
- Every grant passes through 1 IDLE cycle. Each check occupies SETTLE+3 cycles, so with back-to-back requests the grant rate is one per SETTLE+3 cycles.
- A requester that registers the drop of `req` on the `ack` edge is not re-granted. The round-robin pointer also excludes it when other slots are pending.
- `busy` rises the cycle after IDLE sees `req`, and falls on re-entry to IDLE.

## Configuration
- `VPI_CHECK_SCHED_HALT_ON_FAIL_EN`
  - Defined: a mismatch in SAMPLE moves the FSM to HALT instead of IDLE. In HALT, `busy`=1, no grants are issued and requests are held pending. `clr_counts` moves HALT→IDLE on the next edge.
  - Undefined: HALT does not exist, and checking continues after failures.

## Test plan
- Reset, then `req`=6'b000001 held until `ack`, with SETTLE=2 and `mismatch_in`=0 → `check`[0] high 1 cycle after the request edge; `ack`[0] high 3 cycles later; `pass_count`=1; `fail`=0.
- `req`=6'b111111 held continuously and all slots matching → grants 0,1,2,3,4,5,0 in order, one per 5 cycles; `pass_count`=6 after 30 cycles.
- Slot 4 granted with `mismatch_in[4]`=1 → `fail_count`=1, `fail`=1, `last_fail_slot`=4.
  - With `VPI_CHECK_SCHED_HALT_ON_FAIL_EN`: `busy` stays 1 and no further `check` pulses appear until `clr_counts`.
- CNT_W=2 with 5 passing checks → `pass_count` stays 3. `clr_counts` asserted in the same cycle as an `ack` → counters read 0.
- `rst_n` asserted low during SETTLE → `check`/`ack`/`busy` go to 0 asynchronously. After release with `req`=6'b000100, slot 2 is granted with no `ack` for the aborted slot.
